// File: rtl/icache_direct_mapped_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package icache_direct_mapped_pkg;

    // Default geometry of the cache and the fetch/memory address space.
    localparam int ICACHE_ADDR_W     = 32;
    localparam int ICACHE_INST_LEN   = 32;
    localparam int ICACHE_LINES      = 4;
    localparam int ICACHE_LINE_BYTES = 16;

    localparam int ICACHE_OFFSET_W = $clog2(ICACHE_LINE_BYTES);
    localparam int ICACHE_INDEX_W  = $clog2(ICACHE_LINES);
    localparam int ICACHE_TAG_W    = ICACHE_ADDR_W - ICACHE_OFFSET_W - ICACHE_INDEX_W;
    localparam int ICACHE_LINE_W   = ICACHE_LINE_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } icache_state_t;

    typedef struct packed {
        logic                     valid;
        logic [ICACHE_TAG_W-1:0]  tag;
        logic [ICACHE_LINE_W-1:0] data;
    } icache_line_t;

    typedef struct packed {
        logic                     valid;
        logic [ICACHE_ADDR_W-1:0] addr;
    } icache_mem_req_t;

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Line-fill bus between the instruction cache (master) and main memory (slave):
// valid/ready request channel, valid-only response channel.
interface icache_direct_mapped_if
    import icache_direct_mapped_pkg::*;
#(
    parameter int ADDR_W     = ICACHE_ADDR_W,
    parameter int LINE_BYTES = ICACHE_LINE_BYTES
);
    logic                    mem_req_valid;
    logic [ADDR_W-1:0]       mem_req_addr;
    logic                    mem_req_ready;
    logic                    mem_rsp_valid;
    logic [LINE_BYTES*8-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache in front of the fetch stage. Hits are
// answered combinationally; a miss stalls fetch and refills one whole line.
module icache_direct_mapped
    import icache_direct_mapped_pkg::*;
#(
    parameter int ADDR_W     = ICACHE_ADDR_W,
    parameter int INST_LEN   = ICACHE_INST_LEN,
    parameter int NUM_LINES  = ICACHE_LINES,
    parameter int LINE_BYTES = ICACHE_LINE_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fet_req_valid,
    input  logic [ADDR_W-1:0]     fet_addr,
    output logic [INST_LEN-1:0]   inst_out,
    output logic                  inst_valid,
    output logic                  stall_fet_out,
    input  logic                  invalidate,
    icache_direct_mapped_if.master mem
);

    localparam int OFFSET_W   = $clog2(LINE_BYTES);
    localparam int INDEX_W    = $clog2(NUM_LINES);
    localparam int TAG_W      = ADDR_W - OFFSET_W - INDEX_W;
    localparam int WORD_SEL_W = (OFFSET_W > 2) ? OFFSET_W - 2 : 1;

    // The line/request structs are sized from the package defaults.
    if (ADDR_W != ICACHE_ADDR_W || NUM_LINES != ICACHE_LINES ||
        LINE_BYTES != ICACHE_LINE_BYTES) begin : g_geometry_mismatch
        $error("icache_direct_mapped: geometry must match icache_direct_mapped_pkg");
    end

    icache_state_t     state_q, state_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    icache_line_t      lines_q [NUM_LINES];
    icache_line_t      lines_d [NUM_LINES];

    logic [INDEX_W-1:0]    fet_index, miss_index;
    logic [TAG_W-1:0]      fet_tag, miss_tag;
    logic [WORD_SEL_W-1:0] fet_word;
    logic                  hit;
    icache_mem_req_t       mem_req;

    // Split the fetch PC and the outstanding miss address; evaluate the lookup.
    always_comb begin
        fet_index  = fet_addr[OFFSET_W +: INDEX_W];
        fet_tag    = fet_addr[ADDR_W-1 -: TAG_W];
        fet_word   = WORD_SEL_W'(fet_addr[OFFSET_W-1:0] >> 2);
        miss_index = miss_addr_q[OFFSET_W +: INDEX_W];
        miss_tag   = miss_addr_q[ADDR_W-1 -: TAG_W];
        hit        = (state_q == IDLE) && fet_req_valid &&
                     lines_q[fet_index].valid && (lines_q[fet_index].tag == fet_tag);
    end

    // State, miss address and line storage; only control state and valid bits reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
        if (!rst) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            // NOTE: tag/data stay unreset; a cleared valid bit already hides them, so the arrays can map to plain RAM.
            for (int i = 0; i < NUM_LINES; i++) begin
                lines_q[i].valid <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            lines_q     <= lines_d;
        end
    end

    // Next-state logic: latch the miss, track the request handshake, fill the line.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        lines_d     = lines_q;
        unique case (state_q)
            IDLE: begin
                if (fet_req_valid && !hit) begin
                    state_d     = REQ;
                    miss_addr_d = fet_addr;
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rsp_valid) begin
                    state_d             = IDLE;
                    lines_d[miss_index] = {1'b1, miss_tag, mem.mem_rsp_data};
                end
            end
            default: state_d = IDLE;
        endcase
        // Applied after the fill so a coincident invalidate leaves the new line invalid.
        if (invalidate) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines_d[i].valid = 1'b0;
            end
        end
    end

    // Outputs: hit data and stall towards fetch, line request towards memory.
    always_comb begin
        inst_valid    = hit;
        inst_out      = '0;
        stall_fet_out = 1'b0;
        mem_req       = '0;
        unique case (state_q)
            IDLE: begin
                stall_fet_out = fet_req_valid && !hit;
                if (hit) begin
                    inst_out = lines_q[fet_index].data[fet_word*INST_LEN +: INST_LEN];
                end
            end
            REQ: begin
                stall_fet_out = 1'b1;
                mem_req.valid = 1'b1;
                mem_req.addr  = miss_addr_q & ~ADDR_W'(LINE_BYTES - 1);
            end
            WAIT: begin
                stall_fet_out = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem.mem_req_valid = mem_req.valid;
    assign mem.mem_req_addr  = mem_req.addr;

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped instruction cache directly upstream of fetch_stage; supplies the 32-bit instruction for the fetch PC.
- Drives the fetch-side miss stall (stall_fet_out) that the core ORs into stall_fet.
- On a miss, fetches one full line from main memory through a valid/ready request and valid-only response interface.
- Hits return the instruction in the same cycle.

Parameters:
- ADDR_W, 32, fetch/memory address width.
- INST_LEN, 32, instruction width (from constants_pkg).
- NUM_LINES, 4, number of cache lines (power of 2).
- LINE_BYTES, 16, bytes per line (power of 2, ≥4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- fet_req_valid  in  1  fetch presents fet_addr this cycle.
- fet_addr  in  ADDR_W  fetch PC.
- inst_out  out  INST_LEN  instruction word.
- inst_valid  out  1  inst_out valid (hit).
- stall_fet_out  out  1  miss in progress; fetch must hold the PC.
- invalidate  in  1  clear all valid bits (fence.i).
- mem_req_valid  out  1  line request valid.
- mem_req_addr  out  ADDR_W  line-aligned request address.
- mem_req_ready  in  1  memory accepts the request.
- mem_rsp_valid  in  1  line data valid.
- mem_rsp_data  in  LINE_BYTES*8  full line; word 0 in bits [31:0].

Behaviour:
- Address split:
  - offset = fet_addr[log2(LINE_BYTES)-1:0]; word select = offset[.. :2]; bits[1:0] ignored.
  - index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Storage: per line one valid bit, one tag and one data line. All valid bits clear on reset; tag and data arrays are not reset.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Hit (fet_req_valid & valid[index] & tag match) is combinational: inst_valid=1, inst_out=selected word, stall_fet_out=0.
  - Miss with fet_req_valid: stall_fet_out=1 and inst_valid=0 in the same cycle; latch miss_addr=fet_addr; go to REQ.
  - fet_req_valid=0: inst_valid=0, stall=0, remain IDLE.
- REQ: mem_req_valid=1, mem_req_addr=miss_addr with offset bits zeroed. Hold both stable until mem_req_ready=1, then go to WAIT.
- WAIT:
  - mem_req_valid=0.
  - On mem_rsp_valid, write the data, tag and valid bit for the miss index at that edge, then go to IDLE.
  - mem_rsp_valid is ignored in IDLE and REQ.
- stall_fet_out=1 in every cycle spent in REQ or WAIT. inst_valid=0 in REQ and WAIT.
- Miss penalty with ready=1 and a one-cycle response: miss at cycle 0, REQ at cycle 1, WAIT/fill at cycle 2, hit at cycle 3. In general: 1 + request-handshake cycles + response-wait cycles, then the re-lookup cycle.
- fet_addr changing during a miss: the latched miss_addr is serviced. On return to IDLE the current fet_addr is looked up fresh and may miss again.
- invalidate:
  - Clears all valid bits at the clock edge in any state.
  - If it coincides with the fill edge, invalidate wins: the line stays invalid and the FSM still goes to IDLE.
  - It does not abort an outstanding request.
- Simultaneous hit and invalidate in IDLE: this cycle reports the hit, and the next cycle misses.
- Reset (rst=0 at an edge), including mid-miss:
  - FSM to IDLE; all valid bits to 0; miss_addr to 0.
  - Outputs: inst_valid=0, inst_out=0, stall_fet_out=0, mem_req_valid=0, mem_req_addr=0.
  - Memory shares the same reset, so no stale response is expected.
- inst_out is driven 0 whenever inst_valid=0.
- No wrap-around: a line is aligned and never straddles an index boundary.

Decomposition:
- constants_pkg: ICACHE_LINES and ICACHE_LINE_BYTES defaults.
- structure_pkg:
  - icache_state_t, enum {IDLE, REQ, WAIT}.
  - icache_line_t, packed struct {valid, tag, data}.
  - icache_mem_req_t, packed struct {valid, addr}.
- No sub-module needed; tag/data storage is an array of icache_line_t inside the block.

Test Plan:
- Cold miss then hit:
  - Stimulus: after reset, fet_addr=0x100, req valid; ready=1; rsp 1 cycle later with data 0xDDDD_CCCC_BBBB_AAAA_4444_3333_2222_1111.
  - Response: stall 1 for 3 cycles, mem_req_addr=0x100, then inst_out=0x22221111 and inst_valid=1 at cycle 3.
- Word select: after that fill, fet_addr=0x10C → same-cycle hit, inst_out=0xDDDDCCCC, stall=0.
- Conflict eviction:
  - Stimulus: fill 0x100, then fetch 0x140 (same index 0, different tag) → miss and refill; then 0x100 again.
  - Response: 0x100 misses again, with mem_req_addr=0x100.
- Backpressure: mem_req_ready held 0 for 5 cycles → mem_req_valid=1 and mem_req_addr stable throughout, stall held; the FSM reaches WAIT only after ready rises.
- Invalidate:
  - Invalidate asserted together with the fill response → next lookup of the same address misses.
  - Invalidate while in IDLE with a valid line → that line misses next cycle.
- Reset mid-miss: rst=0 while in WAIT → next cycle all outputs 0, FSM IDLE, the previously filled address 0x100 misses.
